// File: rtl/register_display.sv
// Multiplexed hex display of register 1 or the PC, one digit slot at a time with a blank gap.
// Outputs registered; value and showPc snapshotted once per frame so a frame never tears.
module register_display #(
    parameter int VALUE_WIDTH    = 16,
    parameter int PC_WIDTH       = 8,
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int BLANK_CYCLES   = 4,
    parameter int SUPPRESS_ZEROS = 0
) (
    input  logic                   clock,
    input  logic                   isReset,
    input  logic [VALUE_WIDTH-1:0] register1Value,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   showPc,
    output logic [6:0]             segments,
    output logic [NUM_DIGITS-1:0]  anodes,
    output logic                   dp
);

    localparam int FW = 4 * NUM_DIGITS;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (BLANK_CYCLES < 1 || REFRESH_DIV <= BLANK_CYCLES || NUM_DIGITS < 1) begin : g_bad_params
        $error("register_display: illegal BLANK_CYCLES/REFRESH_DIV/NUM_DIGITS combination");
    end

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   digit, digit_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [FW-1:0]   frame;
    logic            frame_pc;
    logic [FW-1:0]   val_ext, pc_ext;
    logic [3:0]      nib;
    logic [DW-1:0]   msd;
    logic            show;
    logic [6:0]      seg_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic            dp_nxt;
    logic            capture;

    if (VALUE_WIDTH >= FW) begin : g_val_trunc
        assign val_ext = register1Value[FW-1:0];
    end else begin : g_val_ext
        assign val_ext = {{(FW-VALUE_WIDTH){1'b0}}, register1Value};
    end

    if (PC_WIDTH >= FW) begin : g_pc_trunc
        assign pc_ext = pc[FW-1:0];
    end else begin : g_pc_ext
        assign pc_ext = {{(FW-PC_WIDTH){1'b0}}, pc};
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // state/digit/cnt name the slot position that the coming edge puts on the outputs
    assign capture = (state == BLANK) && (digit == '0) && (cnt == '0);
    assign nib     = frame[{digit, 2'b00} +: 4];

    always_comb begin
        msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (frame[4*i +: 4] != 4'd0) msd = DW'(i);
        end
    end

    assign show = (SUPPRESS_ZEROS == 0) || (digit <= msd);

    always_comb begin
        state_nxt = state;
        digit_nxt = digit;
        cnt_nxt   = cnt + CW'(1);
        if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt_nxt   = '0;
            state_nxt = BLANK;
            digit_nxt = (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + DW'(1);
        end else if (cnt == CW'(BLANK_CYCLES - 1)) begin
            state_nxt = DRIVE;
        end

        seg_nxt = 7'h7F;
        an_nxt  = '1;
        dp_nxt  = 1'b1;
        if (state == DRIVE && show) begin
            seg_nxt = hex7(nib);
            an_nxt  = ~(NUM_DIGITS'(1) << digit);
            dp_nxt  = !((digit == '0) && frame_pc);
        end
    end

    always_ff @(posedge clock) begin
        if (isReset) begin
            state    <= BLANK;
            digit    <= '0;
            cnt      <= '0;
            frame    <= '0;
            frame_pc <= 1'b0;
            segments <= 7'h7F;
            anodes   <= '1;
            dp       <= 1'b1;
        end else begin
            state    <= state_nxt;
            digit    <= digit_nxt;
            cnt      <= cnt_nxt;
            segments <= seg_nxt;
            anodes   <= an_nxt;
            dp       <= dp_nxt;
            if (capture) begin
                frame    <= showPc ? pc_ext : val_ext;
                frame_pc <= showPc;
            end
        end
    end

endmodule

// File: doc/register_display.md
REGISTER_DISPLAY -- requirements
Module: register_display

Interface
REQ-001 Parameter VALUE_WIDTH, default 16: width of the register1Value input.
REQ-002 Parameter PC_WIDTH, default 8: width of the pc input.
REQ-003 Parameter NUM_DIGITS, default 4: number of hex digits scanned.
REQ-004 Parameter REFRESH_DIV, default 1000: clock cycles per digit slot, blank time included.
REQ-005 Parameter BLANK_CYCLES, default 4: cycles at the start of each slot with all anodes off.
REQ-006 Parameter SUPPRESS_ZEROS, default 0: when 1, leading zero digits are blanked.
REQ-007 Port clock, input, 1: the single clock; all logic on its rising edge.
REQ-008 Port isReset, input, 1: reset, synchronous and active-high.
REQ-009 Port register1Value, input, VALUE_WIDTH: CPU register 1 value to display.
REQ-010 Port pc, input, PC_WIDTH: CPU program counter.
REQ-011 Port showPc, input, 1: 1 selects pc, 0 selects register1Value.
REQ-012 Port segments, output, 7: {g,f,e,d,c,b,a}, active-low.
REQ-013 Port anodes, output, NUM_DIGITS: digit enables, active-low, at most one low.
REQ-014 Port dp, output, 1: decimal point, active-low.

Function
REQ-015 All outputs SHALL be registered; none SHALL depend combinationally on inputs.
REQ-016 FSM states:
- BLANK: all anodes high, segments 7'h7F, dp high; lasts BLANK_CYCLES cycles.
- DRIVE: anodes[digitIndex] low; lasts REFRESH_DIV-BLANK_CYCLES cycles.
REQ-017 DRIVE SHALL be followed by BLANK with digitIndex+1, which wraps from NUM_DIGITS-1 to 0.
REQ-018 Timing: edge 1 is the first rising edge with isReset low. BLANK for digit 0 SHALL cover edges 1..BLANK_CYCLES. anodes[0] SHALL go low at edge BLANK_CYCLES+1.
REQ-019 Frame period SHALL be exactly NUM_DIGITS*REFRESH_DIV cycles.
REQ-020 Snapshot: at the first BLANK cycle of digit 0, the block SHALL capture the selected source into a 4*NUM_DIGITS-bit frame register. A narrower source is zero-extended; a wider source keeps its low bits.
REQ-021 showPc SHALL also be captured at that cycle. Input changes during a frame SHALL NOT alter the frame's display.
REQ-022 Digit n SHALL show nibble n (bits 4n+3:4n) of the frame register.
REQ-023 Hex encoding (active-low, {g..a}):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-024 With SUPPRESS_ZEROS=1, digits above the highest nonzero nibble SHALL keep their anode high for the whole slot. Digit 0 SHALL always be shown, so a value of 0 displays "0".
REQ-025 dp SHALL be low only during DRIVE of digit 0 in a frame whose captured showPc is 1.
REQ-026 Parameters SHALL satisfy BLANK_CYCLES>=1, REFRESH_DIV>BLANK_CYCLES and NUM_DIGITS>=1. Otherwise elaboration SHALL fail.

Reset
REQ-027 While isReset is high at an edge, the block SHALL set:
- anodes all ones, segments 7'h7F, dp 1
- state BLANK, digitIndex 0, slot counter 0
- frame register 0, captured showPc 0
REQ-028 Reset asserted in any state, including mid-DRIVE, SHALL blank outputs at that edge and restart per REQ-018 after release.

Verification (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-029 Reset: hold isReset high 3 cycles -> anodes=4'b1111, segments=7'h7F and dp=1 on every cycle.
REQ-030 Scan: register1Value=16'h12AF, showPc=0 ->
- edges 3-8: anodes=1110, segments=0001110 (F)
- edges 11-16: anodes=1101, A
- edges 19-24: anodes=1011, 2
- edges 27-32: anodes=0111, 1
- edges 35-40: anodes=1110 again
REQ-031 Blanking: anodes=1111 for exactly 2 cycles between every pair of digit slots; anodes never holds two zeros.
REQ-032 Anti-tear: change register1Value to 16'h0000 at edge 12 -> digits 2 and 3 of the current frame still show 2 and 1; the next frame shows all zeros.
REQ-033 PC with suppression (SUPPRESS_ZEROS=1): showPc=1, pc=8'h05 ->
- digit 0 shows 0010010 with dp=0
- digit 1-3 slots: anodes stay 1111
- pc=0: digit 0 shows 1000000
REQ-034 Mid-operation reset: assert isReset for 1 cycle during DRIVE of digit 2 -> all-off outputs at that edge; anodes=1110 again exactly BLANK_CYCLES+1 edges after release.
